// File: rtl/hit_judge_nch.sv
// -----------------------------------------------------------------------------
// hit_judge_nch
//   Multi-channel whack-a-mole hit judge. Each mole channel has its own
//   small FSM (IDLE -> ARMED -> PRIMED -> SPENT). A channel is armed when its
//   LED lights. It is primed by a later toggle of its switch. A hammer press
//   then commits a hit on every primed channel at once.
//   A hammer press with nothing primed is reported as a miss. A switch toggle
//   on a dark channel is reported as stray.
//
// Optional feature (macro HIT_JUDGE_REACTION_TIME_EN):
//   A shared prescaler produces a 1 ms tick. Each channel keeps a saturating
//   reaction-time counter while ARMED/PRIMED. On a hit, rt_ms carries the
//   count of the lowest-index hit channel. With the macro undefined,
//   rt_valid and rt_ms are tied to 0.
//
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   enable        game-running qualifier
//   mole_led      LED vector, clk domain
//   sw_raw        raw asynchronous switches, one per LED
//   hammer_pulse  debounced single-cycle hammer press
//   hit_vec       1-cycle pulse, channels hit
//   hit_pulse     1-cycle pulse, OR of hit_vec
//   miss_pulse    1-cycle pulse, hammer with no primed channel
//   stray_pulse   1-cycle pulse, switch edge on a dark channel
//   primed_vec    level, channels currently PRIMED
//   rt_valid      1-cycle pulse alongside hit_pulse (feature only)
//   rt_ms         reaction time in ms, held until the next hit (feature only)
// -----------------------------------------------------------------------------
module hit_judge_nch #(
    parameter int NUM_CH      = 5,
    parameter int SYNC_STAGES = 2,
    parameter int RT_WIDTH    = 12,
    parameter int RT_PRESCALE = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   mole_led,
    input  logic [NUM_CH-1:0]   sw_raw,
    input  logic                hammer_pulse,
    output logic [NUM_CH-1:0]   hit_vec,
    output logic                hit_pulse,
    output logic                miss_pulse,
    output logic                stray_pulse,
    output logic [NUM_CH-1:0]   primed_vec,
    output logic                rt_valid,
    output logic [RT_WIDTH-1:0] rt_ms
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_PRIMED = 2'd2,
        ST_SPENT  = 2'd3
    } ch_state_t;

    // ---------------- switch synchroniser and edge detect ----------------
    logic [SYNC_STAGES-1:0][NUM_CH-1:0] r_sync;
    logic [NUM_CH-1:0]                  r_sw_prev;
    logic [NUM_CH-1:0]                  r_led_prev;
    logic [NUM_CH-1:0]                  w_sw_s;
    logic [NUM_CH-1:0]                  w_edge;
    logic [NUM_CH-1:0]                  w_rise;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_sw_prev  <= '0;
            r_led_prev <= '0;
        end else begin
            r_sync[0] <= sw_raw;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
            r_sw_prev  <= w_sw_s;
            r_led_prev <= mole_led;
        end
    end

    assign w_sw_s = r_sync[SYNC_STAGES-1];
    assign w_edge = w_sw_s ^ r_sw_prev;      // both polarities count
    assign w_rise = mole_led & ~r_led_prev;

    // r_live is low only on the first clock after reset release. Pulses are
    // masked on that clock so that a release never produces a spurious event.
    logic r_live;

    // ---------------- per-channel FSMs ----------------
    logic [NUM_CH-1:0]                w_primed;     // current state == PRIMED
    logic [NUM_CH-1:0]                w_nxt_primed; // next state == PRIMED
    logic [NUM_CH-1:0]                w_hit;
    logic [NUM_CH-1:0][RT_WIDTH-1:0]  w_rt_all;

`ifdef HIT_JUDGE_REACTION_TIME_EN
    localparam int PW = (RT_PRESCALE > 1) ? $clog2(RT_PRESCALE) : 1;
    logic [PW-1:0] r_presc;
    logic          w_ms_tick;

    // Free-running prescaler. It is not tied to any channel, so any window
    // of N*RT_PRESCALE clocks contains exactly N ticks.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_presc <= '0;
        end else if (w_ms_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + {{(PW-1){1'b0}}, 1'b1};
        end
    end

    assign w_ms_tick = (r_presc == PW'(RT_PRESCALE - 1));
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        ch_state_t r_state;
        ch_state_t w_nxt;

        always_ff @(posedge clk) begin
            if (!rst_n) r_state <= ST_IDLE;
            else        r_state <= w_nxt;
        end

        // A dark LED or a disabled game drops the channel to IDLE. A hammer in
        // the same cycle that a PRIMED LED goes dark still scores, because
        // w_hit looks at the current state, not the next one.
        always_comb begin
            w_nxt = r_state;
            if (!enable || !mole_led[g]) begin
                w_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE:   if (w_rise[g])     w_nxt = ST_ARMED;  // edge on rise is ignored
                    ST_ARMED:  if (w_edge[g])     w_nxt = ST_PRIMED;
                    ST_PRIMED: if (hammer_pulse)  w_nxt = ST_SPENT;
                    ST_SPENT:                     w_nxt = ST_SPENT;
                    default:                      w_nxt = ST_IDLE;
                endcase
            end
        end

        assign w_primed[g]     = (r_state == ST_PRIMED);
        assign w_nxt_primed[g] = (w_nxt == ST_PRIMED);
        assign w_hit[g]        = r_live & enable & hammer_pulse & (r_state == ST_PRIMED);

`ifdef HIT_JUDGE_REACTION_TIME_EN
        logic [RT_WIDTH-1:0] r_rt;

        always_ff @(posedge clk) begin
            if (!rst_n || !enable) begin
                r_rt <= '0;
            end else if (w_nxt == ST_ARMED && r_state != ST_ARMED) begin
                r_rt <= '0;
            end else if (w_ms_tick && (r_state == ST_ARMED || r_state == ST_PRIMED)
                         && (r_rt != {RT_WIDTH{1'b1}})) begin
                r_rt <= r_rt + {{(RT_WIDTH-1){1'b0}}, 1'b1};
            end
        end

        assign w_rt_all[g] = r_rt;
`else
        assign w_rt_all[g] = '0;
`endif
    end

    // ---------------- registered event outputs ----------------
    logic [NUM_CH-1:0] r_hit_vec;
    logic              r_hit_pulse;
    logic              r_miss;
    logic              r_stray;
    logic [NUM_CH-1:0] r_primed;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_hit_vec   <= '0;
            r_hit_pulse <= 1'b0;
            r_miss      <= 1'b0;
            r_stray     <= 1'b0;
            r_primed    <= '0;
        end else begin
            r_live      <= 1'b1;
            r_hit_vec   <= w_hit;
            r_hit_pulse <= |w_hit;
            r_miss      <= r_live & enable & hammer_pulse & ~(|w_primed);
            r_stray     <= r_live & enable & (|(w_edge & ~mole_led & ~w_rise));
            r_primed    <= w_nxt_primed;
        end
    end

    assign hit_vec     = r_hit_vec;
    assign hit_pulse   = r_hit_pulse;
    assign miss_pulse  = r_miss;
    assign stray_pulse = r_stray;
    assign primed_vec  = r_primed;

    // ---------------- reaction-time report ----------------
`ifdef HIT_JUDGE_REACTION_TIME_EN
    logic [RT_WIDTH-1:0] w_rt_sel;
    logic                r_rt_valid;
    logic [RT_WIDTH-1:0] r_rt_ms;

    // Scan downwards so that the lowest-index hit channel wins.
    always_comb begin
        w_rt_sel = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (w_hit[i]) w_rt_sel = w_rt_all[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rt_valid <= 1'b0;
            r_rt_ms    <= '0;
        end else begin
            r_rt_valid <= |w_hit;
            if (|w_hit) r_rt_ms <= w_rt_sel;
        end
    end

    assign rt_valid = r_rt_valid;
    assign rt_ms    = r_rt_ms;
`else
    logic w_rt_unused;
    assign w_rt_unused = |w_rt_all;
    assign rt_valid    = 1'b0;
    assign rt_ms       = '0;
`endif

endmodule

// File: tb/tb_hit_judge_nch.sv
// -----------------------------------------------------------------------------
// tb_hit_judge_nch
//   Directed bench for hit_judge_nch with NUM_CH=5 and SYNC_STAGES=2.
//   Inputs are driven 1 time unit after the rising edge, and outputs are
//   sampled at that same point. A switch change driven before edge k is
//   seen as an edge at edge k+2.
//   With HIT_JUDGE_REACTION_TIME_EN the bench uses RT_PRESCALE=10 and
//   RT_WIDTH=6, so 64 or more ticks saturate at 63.
// -----------------------------------------------------------------------------
module tb_hit_judge_nch;

    localparam int NCH = 5;
`ifdef HIT_JUDGE_REACTION_TIME_EN
    localparam int RTP = 10;
    localparam int RTW = 6;
`else
    localparam int RTP = 100000;
    localparam int RTW = 12;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           enable;
    logic [NCH-1:0] mole_led;
    logic [NCH-1:0] sw_raw;
    logic           hammer_pulse;
    logic [NCH-1:0] hit_vec;
    logic           hit_pulse;
    logic           miss_pulse;
    logic           stray_pulse;
    logic [NCH-1:0] primed_vec;
    logic           rt_valid;
    logic [RTW-1:0] rt_ms;

    int checks = 0;
    int errors = 0;

    hit_judge_nch #(
        .NUM_CH      (NCH),
        .SYNC_STAGES (2),
        .RT_WIDTH    (RTW),
        .RT_PRESCALE (RTP)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .mole_led     (mole_led),
        .sw_raw       (sw_raw),
        .hammer_pulse (hammer_pulse),
        .hit_vec      (hit_vec),
        .hit_pulse    (hit_pulse),
        .miss_pulse   (miss_pulse),
        .stray_pulse  (stray_pulse),
        .primed_vec   (primed_vec),
        .rt_valid     (rt_valid),
        .rt_ms        (rt_ms)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; mole_led = '0; sw_raw = '0; hammer_pulse = 1'b0;
        repeat (3) tick();
        chk("rst_hit_vec", 32'(hit_vec), 0);
        chk("rst_hit",     32'(hit_pulse), 0);
        chk("rst_miss",    32'(miss_pulse), 0);
        chk("rst_stray",   32'(stray_pulse), 0);
        chk("rst_primed",  32'(primed_vec), 0);
        chk("rst_rt_vld",  32'(rt_valid), 0);
        chk("rst_rt_ms",   32'(rt_ms), 0);
        rst_n = 1'b1;
        tick();

        // 1: basic hit, then a second press on a SPENT channel is a miss
        mole_led = 5'b00100;
        repeat (10) tick();
        sw_raw[2] = 1'b1;
        repeat (3) tick();
        chk("t1_primed", 32'(primed_vec), 32'h04);
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t1_hit_vec", 32'(hit_vec), 32'h04);
        chk("t1_hit",     32'(hit_pulse), 1);
        chk("t1_miss",    32'(miss_pulse), 0);
`ifndef HIT_JUDGE_REACTION_TIME_EN
        chk("t1_rt_vld",  32'(rt_valid), 0);
        chk("t1_rt_ms",   32'(rt_ms), 0);
`endif
        tick();
        chk("t1_hit_once", 32'(hit_pulse), 0);
        chk("t1_vec_once", 32'(hit_vec), 0);
        chk("t1_spent",    32'(primed_vec), 0);
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t1_re_miss", 32'(miss_pulse), 1);
        chk("t1_re_hit",  32'(hit_pulse), 0);
        mole_led = '0; tick();

        // raise sw[1] while dark: stray, and sets up a falling edge for test 2
        sw_raw[1] = 1'b1;
        repeat (3) tick();
        chk("t2_pre_stray", 32'(stray_pulse), 1);
        tick();
        chk("t2_stray_off", 32'(stray_pulse), 0);

        // 2: no toggle gives a miss; a falling edge primes
        mole_led = 5'b00010;
        tick(); tick();
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t2_miss",    32'(miss_pulse), 1);
        chk("t2_nohit",   32'(hit_vec), 0);
        sw_raw[1] = 1'b0;
        repeat (3) tick();
        chk("t2_primed",  32'(primed_vec), 32'h02);
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t2_hit_vec", 32'(hit_vec), 32'h02);
        chk("t2_hit",     32'(hit_pulse), 1);
        mole_led = '0; tick();

        // 3: stray on dark channel 0; a toggle coinciding with a rise only arms
        sw_raw[0] = 1'b1;
        repeat (3) tick();
        chk("t3_stray", 32'(stray_pulse), 1);
        tick();
        chk("t3_stray_off", 32'(stray_pulse), 0);
        sw_raw[3] = 1'b1;
        tick(); tick();
        mole_led = 5'b01000;
        tick();
        chk("t3_sim_stray",  32'(stray_pulse), 0);
        chk("t3_sim_primed", 32'(primed_vec), 0);
        tick();
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t3_armed_miss", 32'(miss_pulse), 1);
        chk("t3_armed_hit",  32'(hit_pulse), 0);
        mole_led = '0; tick();

        // 4: multi-hit, with the LEDs falling in the hammer cycle
        mole_led = 5'b10010;
        tick(); tick();
        sw_raw[1] = 1'b1; sw_raw[4] = 1'b1;
        repeat (3) tick();
        chk("t4_primed", 32'(primed_vec), 32'h12);
        hammer_pulse = 1'b1; mole_led = '0;
        tick();
        hammer_pulse = 1'b0;
        chk("t4_hit_vec", 32'(hit_vec), 32'h12);
        chk("t4_hit",     32'(hit_pulse), 1);
        chk("t4_miss",    32'(miss_pulse), 0);
        chk("t4_idle",    32'(primed_vec), 0);
        tick();
        chk("t4_hit_once", 32'(hit_pulse), 0);

        // 5: enable drop clears priming and suppresses pulses
        mole_led = 5'b00001;
        tick(); tick();
        sw_raw[0] = 1'b0;
        repeat (3) tick();
        chk("t5_primed", 32'(primed_vec), 32'h01);
        enable = 1'b0; tick();
        chk("t5_dis_primed", 32'(primed_vec), 0);
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t5_dis_miss", 32'(miss_pulse), 0);
        chk("t5_dis_hit",  32'(hit_pulse), 0);
        enable = 1'b1;
        mole_led = '0; tick();
        mole_led = 5'b00001; tick();
        sw_raw[0] = 1'b1;
        repeat (3) tick();
        chk("t5_reprimed", 32'(primed_vec), 32'h01);
        // 5b: reset mid-game, with the hammer held across the release edge
        rst_n = 1'b0; hammer_pulse = 1'b1; tick();
        chk("t5_rst_primed", 32'(primed_vec), 0);
        chk("t5_rst_hit",    32'(hit_pulse), 0);
        chk("t5_rst_vec",    32'(hit_vec), 0);
        chk("t5_rst_miss",   32'(miss_pulse), 0);
        chk("t5_rst_stray",  32'(stray_pulse), 0);
        rst_n = 1'b1; tick();
        chk("t5_rel_miss", 32'(miss_pulse), 0);
        chk("t5_rel_hit",  32'(hit_pulse), 0);
        tick();
        chk("t5_post_miss", 32'(miss_pulse), 1);
        hammer_pulse = 1'b0;
        repeat (5) tick();
        mole_led = '0; tick();

`ifdef HIT_JUDGE_REACTION_TIME_EN
        // 6: 570 clk between arm and hit gives 57 ms; a long wait saturates
        mole_led = 5'b00100; tick();
        sw_raw[2] = 1'b0;
        repeat (569) tick();
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t6_hit",    32'(hit_pulse), 1);
        chk("t6_rt_vld", 32'(rt_valid), 1);
        chk("t6_rt_ms",  32'(rt_ms), 57);
        mole_led = '0; tick();
        mole_led = 5'b00100; tick();
        sw_raw[2] = 1'b1;
        repeat (1000) tick();
        hammer_pulse = 1'b1; tick(); hammer_pulse = 1'b0;
        chk("t6_sat_vld", 32'(rt_valid), 1);
        chk("t6_sat_ms",  32'(rt_ms), 63);
        tick();
        chk("t6_vld_once", 32'(rt_valid), 0);
        chk("t6_ms_hold",  32'(rt_ms), 63);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
